// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline register fields in, stall/forward controls out
interface hazard_ctrl_if;
  // D stage
  logic [4:0]  A1D;
  logic [4:0]  A2D;
  logic [2:0]  Tuse1D;
  logic [2:0]  Tuse2D;
  logic        md_use_D;
  // E stage
  logic [4:0]  A1E;
  logic [4:0]  A2E;
  logic [4:0]  A3E;
  logic [2:0]  TnewE;
  logic        md_start;
  logic        md_is_div;
  // M stage
  logic [4:0]  A2M;
  logic [4:0]  A3M;
  logic [2:0]  TnewM;
  // W stage
  logic [4:0]  A3W;
  // controls back to the datapath
  logic        stall;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic [1:0]  fwd_rt_M;
  logic        md_busy;
  logic [31:0] stall_cnt;

  // datapath side: supplies pipeline register fields, consumes controls
  modport master (
    output A1D, A2D, Tuse1D, Tuse2D, md_use_D,
    output A1E, A2E, A3E, TnewE, md_start, md_is_div,
    output A2M, A3M, TnewM, A3W,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
    input  md_busy, stall_cnt
  );

  // hazard controller side
  modport slave (
    input  A1D, A2D, Tuse1D, Tuse2D, md_use_D,
    input  A1E, A2E, A3E, TnewE, md_start, md_is_div,
    input  A2M, A3M, TnewM, A3W,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
    output md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forward decisions, mult/div busy sequencing, stall counter
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [1:0] SEL_OWN = 2'd0;
  localparam logic [1:0] SEL_E   = 2'd1;
  localparam logic [1:0] SEL_M   = 2'd2;
  localparam logic [1:0] SEL_W   = 2'd3;

  logic [CW-1:0] md_cnt;
  logic [31:0]   stall_cnt_q;
  logic          md_busy;
  logic          data_stall;
  logic          md_stall;
  logic          stall;

  // $0 is hard-wired, so it never participates in a dependency
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // D-stage operand select: youngest ready producer wins (E, then M, then W)
  function automatic logic [1:0] sel_d(input logic [4:0] src);
    logic [1:0] sel;
    sel = SEL_OWN;
    if (hit(src, bus.A3E) && (bus.TnewE == 3'd0))
      sel = SEL_E;
    else if (hit(src, bus.A3M) && (bus.TnewM == 3'd0))
      sel = SEL_M;
    else if (hit(src, bus.A3W))
      sel = SEL_W;
    return sel;
  endfunction

  // E-stage operand select: E cannot forward to itself, so only M or W
  function automatic logic [1:0] sel_e(input logic [4:0] src);
    logic [1:0] sel;
    sel = SEL_OWN;
    if (hit(src, bus.A3M) && (bus.TnewM == 3'd0))
      sel = SEL_M;
    else if (hit(src, bus.A3W))
      sel = SEL_W;
    return sel;
  endfunction

  // a D operand stalls when a producer in E or M cannot deliver before it is used
  function automatic logic dep_stall(input logic [4:0] src, input logic [2:0] tuse);
    return (src != 5'd0) &&
           (((src == bus.A3E) && (bus.TnewE > tuse)) ||
            ((src == bus.A3M) && (bus.TnewM > tuse)));
  endfunction

  // same-cycle hazard decisions; forward selects stay valid even while stalling
  always_comb begin
    data_stall   = dep_stall(bus.A1D, bus.Tuse1D) || dep_stall(bus.A2D, bus.Tuse2D);
    md_busy      = bus.md_start || (md_cnt != '0);
    md_stall     = bus.md_use_D && md_busy;
    stall        = data_stall || md_stall;
    bus.fwd_rs_D = sel_d(bus.A1D);
    bus.fwd_rt_D = sel_d(bus.A2D);
    bus.fwd_rs_E = sel_e(bus.A1E);
    bus.fwd_rt_E = sel_e(bus.A2E);
    bus.fwd_rt_M = hit(bus.A2M, bus.A3W) ? SEL_W : SEL_OWN;
  end

  assign bus.stall     = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

  // mult/div busy countdown; a new issue always reloads the full latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      md_cnt <= '0;
    else if (bus.md_start)
      md_cnt <= bus.md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  // debug count of stalled cycles, pinned at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  rs_d;
    logic [1:0]  rt_d;
    logic [1:0]  rs_e;
    logic [1:0]  rt_e;
    logic [1:0]  rt_m;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.A1D = 5'd0; bus.A2D = 5'd0; bus.Tuse1D = 3'd0; bus.Tuse2D = 3'd0;
    bus.md_use_D = 1'b0;
    bus.A1E = 5'd0; bus.A2E = 5'd0; bus.A3E = 5'd0; bus.TnewE = 3'd0;
    bus.md_start = 1'b0; bus.md_is_div = 1'b0;
    bus.A2M = 5'd0; bus.A3M = 5'd0; bus.TnewM = 3'd0;
    bus.A3W = 5'd0;
  endtask

  task automatic push(input string name, input logic st,
                      input logic [1:0] rs_d, input logic [1:0] rt_d,
                      input logic [1:0] rs_e, input logic [1:0] rt_e,
                      input logic [1:0] rt_m, input logic busy,
                      input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.stall = st; e.rs_d = rs_d; e.rt_d = rt_d;
    e.rs_e = rs_e; e.rt_e = rt_e; e.rt_m = rt_m; e.busy = busy; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, expv);
    end
  endtask

  // monitor: sample mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "stall",     {31'd0, bus.stall},    {31'd0, e.stall});
      chk(e.name, "fwd_rs_D",  {30'd0, bus.fwd_rs_D}, {30'd0, e.rs_d});
      chk(e.name, "fwd_rt_D",  {30'd0, bus.fwd_rt_D}, {30'd0, e.rt_d});
      chk(e.name, "fwd_rs_E",  {30'd0, bus.fwd_rs_E}, {30'd0, e.rs_e});
      chk(e.name, "fwd_rt_E",  {30'd0, bus.fwd_rt_E}, {30'd0, e.rt_e});
      chk(e.name, "fwd_rt_M",  {30'd0, bus.fwd_rt_M}, {30'd0, e.rt_m});
      chk(e.name, "md_busy",   {31'd0, bus.md_busy},  {31'd0, e.busy});
      chk(e.name, "stall_cnt", bus.stall_cnt,         e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    rst = 1'b1;
    step();
    push("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    push("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // lw $2 in E, beq in D reading $2 now: stall, counter steps per edge
    clear_inputs();
    bus.A3E = 5'd2; bus.TnewE = 3'd2; bus.A1D = 5'd2; bus.Tuse1D = 3'd0;
    for (int i = 0; i < 3; i++) begin
      push("lw_beq", 1, 0, 0, 0, 0, 0, 0, 32'(i));
      step();
    end

    // ready M result beats W for the same register
    clear_inputs();
    bus.A3M = 5'd3; bus.TnewM = 3'd0; bus.A1E = 5'd3; bus.A3W = 5'd3;
    push("m_beats_w", 0, 0, 0, 2, 0, 0, 0, 3);
    step();

    // M not ready yet: fall back to W; D rt has slack, so no stall
    clear_inputs();
    bus.A3M = 5'd3; bus.TnewM = 3'd1; bus.A1E = 5'd3; bus.A3W = 5'd3;
    bus.A2D = 5'd3; bus.Tuse2D = 3'd2;
    push("w_fallback", 0, 0, 3, 3, 0, 0, 0, 3);
    step();

    // $0 never forwards or stalls even with a late producer "writing" it
    clear_inputs();
    bus.A3E = 5'd0; bus.TnewE = 3'd5; bus.A1D = 5'd0; bus.Tuse1D = 3'd0;
    push("zero_reg", 0, 0, 0, 0, 0, 0, 0, 3);
    step();

    // all stages write $4: D prefers E, E prefers M, M rt takes W
    clear_inputs();
    bus.A3E = 5'd4; bus.TnewE = 3'd0; bus.A3M = 5'd4; bus.TnewM = 3'd0;
    bus.A3W = 5'd4; bus.A1D = 5'd4; bus.Tuse1D = 3'd1; bus.A2D = 5'd4;
    bus.A2E = 5'd4; bus.A2M = 5'd4;
    push("priority", 0, 1, 1, 0, 2, 3, 0, 3);
    step();

    // rs stall from an M producer still two cycles out
    clear_inputs();
    bus.A3M = 5'd6; bus.TnewM = 3'd2; bus.A1D = 5'd6; bus.Tuse1D = 3'd1;
    push("m_stall_rs", 1, 0, 0, 0, 0, 0, 0, 3);
    step();

    // rt stall from an E producer
    clear_inputs();
    bus.A3E = 5'd7; bus.TnewE = 3'd1; bus.A2D = 5'd7; bus.Tuse2D = 3'd0;
    push("e_stall_rt", 1, 0, 0, 0, 0, 0, 0, 4);
    step();

    // M rt matching M's own destination is not a forward source
    clear_inputs();
    bus.A2M = 5'd8; bus.A3M = 5'd8;
    push("m_no_self", 0, 0, 0, 0, 0, 0, 0, 5);
    step();

    // mult then mflo: 6 stalled cycles
    clear_inputs();
    bus.md_start = 1'b1; bus.md_is_div = 1'b0; bus.md_use_D = 1'b1;
    push("mult_issue", 1, 0, 0, 0, 0, 0, 1, 5);
    step();
    bus.md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("mult_wait", 1, 0, 0, 0, 0, 0, 1, 32'(6 + i));
      step();
    end
    push("mult_done", 0, 0, 0, 0, 0, 0, 0, 11);
    step();

    // div then mflo: 11 stalled cycles
    bus.md_start = 1'b1; bus.md_is_div = 1'b1; bus.md_use_D = 1'b1;
    push("div_issue", 1, 0, 0, 0, 0, 0, 1, 11);
    step();
    bus.md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("div_wait", 1, 0, 0, 0, 0, 0, 1, 32'(12 + i));
      step();
    end
    push("div_done", 0, 0, 0, 0, 0, 0, 0, 22);
    step();

    // busy alone does not stall a non-HI/LO instruction
    bus.md_start = 1'b1; bus.md_is_div = 1'b1; bus.md_use_D = 1'b0;
    push("div_nouse", 0, 0, 0, 0, 0, 0, 1, 22);
    step();
    bus.md_start = 1'b0; bus.md_use_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("div_hilo", 1, 0, 0, 0, 0, 0, 1, 32'(22 + i));
      step();
    end

    // countdown now at 7, stall_cnt at 25: async reset clears before next edge
    push("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    step();
    clear_inputs();
    push("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // saturation: preload near the top, then keep stalling
    clear_inputs();
    bus.A3E = 5'd2; bus.TnewE = 3'd2; bus.A1D = 5'd2; bus.Tuse1D = 3'd0;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    push("sat_fd", 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFD);
    step();
    push("sat_fe", 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE);
    step();
    for (int i = 0; i < 3; i++) begin
      push("sat_ff", 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
      step();
    end

    clear_inputs();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
